// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag byte layout, divider state encoding, datapath width.
package alu_pkg;

    localparam int unsigned ALU_W   = 8;

    localparam int unsigned FLAG_ZF = 0;
    localparam int unsigned FLAG_CF = 1;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_NF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Build a flag byte in the CPU flag register layout {4'b0, NF, OF, CF, ZF}.
    function automatic logic [7:0] pack_flags(input logic nf, input logic of,
                                              input logic cf, input logic zf);
        logic [7:0] f;
        f          = '0;
        f[FLAG_NF] = nf;
        f[FLAG_OF] = of;
        f[FLAG_CF] = cf;
        f[FLAG_ZF] = zf;
        return f;
    endfunction

endpackage

// File: rtl/div_sub_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_sub_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // Difference is kept when non-negative; either result is below the divisor, so WIDTH bits suffice.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = {1'b0, shifted} - {2'b00, divisor_i};
        q_o     = ~diff[WIDTH+1];
        rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider returning quotient, remainder and ALU-layout flags.
// Signed division is compiled in only when SEQ_DIVIDER_SIGNED_EN is defined;
// otherwise signed_op is ignored and every operation is unsigned.
module seq_divider
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [7:0]       flags
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dvd_q;   // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] quo_q, rmd_q;
    logic [7:0]       flags_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             neg_quo_q, neg_rem_q;
`endif

    logic             signed_en, dvd_neg, dvs_neg, div_zero, sgn_ovf;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] step_rem, quo_next, fin_quo, fin_rem;
    logic             step_q;

    div_sub_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // Operand classification at accept time and sign correction of the final step.
    always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        signed_en = signed_op;
`else
        signed_en = 1'b0;
`endif
        dvd_neg  = signed_en & dividend[WIDTH-1];
        dvs_neg  = signed_en & divisor[WIDTH-1];
        // 0x80 negates to itself, which read as unsigned is the correct magnitude 128.
        dvd_mag  = dvd_neg ? (~dividend + 1'b1) : dividend;
        dvs_mag  = dvs_neg ? (~divisor + 1'b1) : divisor;
        div_zero = (divisor == '0);
        sgn_ovf  = signed_en && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
        quo_next = {dvd_q[WIDTH-2:0], step_q};
`ifdef SEQ_DIVIDER_SIGNED_EN
        fin_quo  = neg_quo_q ? (~quo_next + 1'b1) : quo_next;
        fin_rem  = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
`else
        fin_quo  = quo_next;
        fin_rem  = step_rem;
`endif
    end

    // Control FSM with registered datapath and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= '0;
            rmd_q     <= '0;
            flags_q   <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (div_zero) begin
                            quo_q   <= '1;
                            rmd_q   <= dividend;
                            flags_q <= pack_flags(1'b0, 1'b0, 1'b1, 1'b0);
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (sgn_ovf) begin
                            quo_q   <= {1'b1, {(WIDTH-1){1'b0}}};
                            rmd_q   <= '0;
                            flags_q <= pack_flags(1'b0, 1'b1, 1'b0, 1'b0);
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            dvd_q     <= dvd_mag;
                            dvs_q     <= dvs_mag;
                            rem_q     <= '0;
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
                            neg_quo_q <= dvd_neg ^ dvs_neg;
                            neg_rem_q <= dvd_neg;
`endif
                            state_q   <= RUN;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    rem_q <= step_rem;
                    dvd_q <= quo_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        quo_q   <= fin_quo;
                        rmd_q   <= fin_rem;
                        flags_q <= pack_flags(fin_quo[WIDTH-1], 1'b0, 1'b0, fin_quo == '0);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign flags     = flags_q;

endmodule
